// File: rtl/subleq_mem_arbiter.sv
// Single-port BRAM arbiter between Subleq fetch and data stages; routes 1-cycle read data to its owner.
// Optional feature: define ARB_RR_EN for round-robin arbitration instead of dm priority with starvation override.
module subleq_mem_arbiter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG  = 10,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [DEPTH_LOG-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [WIDTH-1:0]     if_rdata,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [DEPTH_LOG-1:0] dm_addr,
    input  logic [WIDTH-1:0]     dm_wdata,
    output logic                 dm_gnt,
    output logic                 dm_rvalid,
    output logic [WIDTH-1:0]     dm_rdata,
    output logic                 bram_en,
    output logic                 bram_we,
    output logic [DEPTH_LOG-1:0] bram_addr,
    output logic [WIDTH-1:0]     bram_din,
    input  logic [WIDTH-1:0]     bram_dout
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RET_IF = 2'd1,
        RET_DM = 2'd2
    } ret_state_t;

    ret_state_t       r_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_if_wins;

`ifdef ARB_RR_EN
    typedef enum logic {
        PORT_DM = 1'b0,
        PORT_IF = 1'b1
    } port_t;

    port_t r_rr_last;

    // Under contention the port that did not win last time gets the grant.
    assign w_if_wins = (r_rr_last == PORT_DM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= PORT_DM;
        end else if (if_gnt) begin
            r_rr_last <= PORT_IF;
        end else if (dm_gnt) begin
            r_rr_last <= PORT_DM;
        end
    end
`else
    assign w_if_wins = (r_starve_cnt == CNT_W'(STARVE_MAX));
`endif

    // Grants are combinational so the BRAM sees the request in the same cycle.
    assign if_gnt = !rst && if_req && (!dm_req || w_if_wins);
    assign dm_gnt = !rst && dm_req && !(if_req && w_if_wins);

    assign bram_en   = if_gnt || dm_gnt;
    assign bram_we   = dm_gnt && dm_we;
    assign bram_addr = dm_gnt ? dm_addr : if_addr;
    assign bram_din  = dm_wdata;

    // Read data is shared; rvalid selects the owner. Reset drops a pending return.
    assign if_rdata  = bram_dout;
    assign dm_rdata  = bram_dout;
    assign if_rvalid = (r_state == RET_IF) && !rst;
    assign dm_rvalid = (r_state == RET_DM) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            if (if_gnt) begin
                r_state <= RET_IF;
            end else if (dm_gnt && !dm_we) begin
                r_state <= RET_DM;
            end else begin
                r_state <= IDLE;
            end

            if (!if_req || if_gnt) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// Bench for subleq_mem_arbiter: directed vector table, then randomized traffic against a reference model.
module tb_subleq_mem_arbiter;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned DEPTH_LOG = 10;
    localparam int unsigned SMAX      = 3;
    localparam int unsigned NWORDS    = 1 << DEPTH_LOG;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 if_req, if_gnt, if_rvalid;
    logic [DEPTH_LOG-1:0] if_addr;
    logic [WIDTH-1:0]     if_rdata;
    logic                 dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [DEPTH_LOG-1:0] dm_addr;
    logic [WIDTH-1:0]     dm_wdata, dm_rdata;
    logic                 bram_en, bram_we;
    logic [DEPTH_LOG-1:0] bram_addr;
    logic [WIDTH-1:0]     bram_din, bram_dout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    subleq_mem_arbiter #(.WIDTH(WIDTH), .DEPTH_LOG(DEPTH_LOG), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    function automatic logic [WIDTH-1:0] init_val(input int i);
        if (i == 0) return 8'h11;
        if (i == 1) return 8'h22;
        if (i == 2) return 8'h33;
        return WIDTH'((i * 37 + 11) & 255);
    endfunction

    // Single-port BRAM model: registered output, output follows written data on writes.
    logic [WIDTH-1:0] mem [NWORDS];
    initial begin
        for (int i = 0; i < int'(NWORDS); i++) mem[i] = init_val(i);
        bram_dout = '0;
    end
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                mem[bram_addr] <= bram_din;
                bram_dout      <= bram_din;
            end else begin
                bram_dout <= mem[bram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic                 rst;
        logic                 ireq;
        logic [DEPTH_LOG-1:0] iaddr;
        logic                 dreq;
        logic                 dwe;
        logic [DEPTH_LOG-1:0] daddr;
        logic [WIDTH-1:0]     dwdata;
        logic                 eig;
        logic                 edg;
        logic                 eiv;
        logic                 edv;
        logic [WIDTH-1:0]     erd;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic ir, input int ia,
                                input logic dr, input logic dw, input int da, input int dd,
                                input logic eig, input logic edg, input logic eiv,
                                input logic edv, input logic [WIDTH-1:0] erd);
        vec_t v;
        v.rst = r; v.ireq = ir; v.iaddr = DEPTH_LOG'(ia);
        v.dreq = dr; v.dwe = dw; v.daddr = DEPTH_LOG'(da); v.dwdata = WIDTH'(dd);
        v.eig = eig; v.edg = edg; v.eiv = eiv; v.edv = edv; v.erd = erd;
        return v;
    endfunction

    localparam int NVEC = 24;
    vec_t tbl [NVEC];

    // Reference model state for the random phase.
    logic [WIDTH-1:0] shadow [NWORDS];

    initial begin
        logic                 ip, dp, dw, r, eg_if, eg_dm;
        logic [DEPTH_LOG-1:0] ia, da;
        logic [WIDTH-1:0]     dd, exp_data;
        int                   starve, owner;

        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        // rst r   ir ia  dr dw da dd     eig edg eiv edv erd
        tbl[0]  = mk(1, 1, 0, 1, 0, 3, 0,    0, 0, 0, 0, 8'h00);
        tbl[1]  = mk(1, 1, 0, 1, 0, 3, 0,    0, 0, 0, 0, 8'h00);
        tbl[2]  = mk(0, 1, 0, 1, 0, 3, 0,    0, 1, 0, 0, 8'h00);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0,    1, 0, 0, 1, init_val(3));
        tbl[4]  = mk(0, 1, 1, 0, 0, 0, 0,    1, 0, 1, 0, 8'h11);
        tbl[5]  = mk(0, 1, 2, 0, 0, 0, 0,    1, 0, 1, 0, 8'h22);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 8'h33);
        tbl[7]  = mk(0, 0, 0, 1, 1, 5, 'hA5, 0, 1, 0, 0, 8'h00);
        tbl[8]  = mk(0, 0, 0, 1, 0, 5, 0,    0, 1, 0, 0, 8'h00);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 8'hA5);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 8'h00);
        tbl[11] = mk(0, 1, 7, 1, 0, 6, 0,    0, 1, 0, 0, 8'h00);
        tbl[12] = mk(0, 1, 7, 1, 0, 6, 0,    0, 1, 0, 1, init_val(6));
        tbl[13] = mk(0, 1, 7, 1, 0, 6, 0,    0, 1, 0, 1, init_val(6));
        tbl[14] = mk(0, 1, 7, 1, 0, 6, 0,    1, 0, 0, 1, init_val(6));
        tbl[15] = mk(0, 1, 7, 1, 0, 6, 0,    0, 1, 1, 0, init_val(7));
        tbl[16] = mk(0, 1, 7, 1, 0, 6, 0,    0, 1, 0, 1, init_val(6));
        tbl[17] = mk(0, 1, 7, 1, 0, 6, 0,    0, 1, 0, 1, init_val(6));
        tbl[18] = mk(0, 1, 7, 1, 0, 6, 0,    1, 0, 0, 1, init_val(6));
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 0, init_val(7));
        tbl[20] = mk(0, 1, 1, 0, 0, 0, 0,    1, 0, 0, 0, 8'h00);
        tbl[21] = mk(1, 1, 1, 0, 0, 0, 0,    0, 0, 0, 0, 8'h00);
        tbl[22] = mk(0, 1, 1, 0, 0, 0, 0,    1, 0, 0, 0, 8'h00);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 8'h22);

        for (int k = 0; k < NVEC; k++) begin
            @(negedge clk);
            rst = tbl[k].rst; if_req = tbl[k].ireq; if_addr = tbl[k].iaddr;
            dm_req = tbl[k].dreq; dm_we = tbl[k].dwe; dm_addr = tbl[k].daddr;
            dm_wdata = tbl[k].dwdata;
            #1;
            check($sformatf("vec%0d if_gnt", k), 32'(if_gnt), 32'(tbl[k].eig));
            check($sformatf("vec%0d dm_gnt", k), 32'(dm_gnt), 32'(tbl[k].edg));
            check($sformatf("vec%0d if_rvalid", k), 32'(if_rvalid), 32'(tbl[k].eiv));
            check($sformatf("vec%0d dm_rvalid", k), 32'(dm_rvalid), 32'(tbl[k].edv));
            check($sformatf("vec%0d bram_en", k), 32'(bram_en), 32'(tbl[k].eig | tbl[k].edg));
            check($sformatf("vec%0d bram_we", k), 32'(bram_we), 32'(tbl[k].edg & tbl[k].dwe));
            if (tbl[k].eiv) check($sformatf("vec%0d if_rdata", k), 32'(if_rdata), 32'(tbl[k].erd));
            if (tbl[k].edv) check($sformatf("vec%0d dm_rdata", k), 32'(dm_rdata), 32'(tbl[k].erd));
        end

        // Random phase: requests are held until granted; model counts consecutive fetch denials.
        for (int i = 0; i < int'(NWORDS); i++) shadow[i] = init_val(i);
        shadow[5] = 8'hA5;
        ip = 1'b0; dp = 1'b0; dw = 1'b0; ia = '0; da = '0; dd = '0;
        starve = 0; owner = 0; exp_data = '0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = ($urandom_range(0, 99) == 0);
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1'b1; ia = DEPTH_LOG'($urandom_range(0, 15));
            end
            if (!dp && $urandom_range(0, 1) == 0) begin
                dp = 1'b1; dw = 1'($urandom_range(0, 1));
                da = DEPTH_LOG'($urandom_range(0, 15)); dd = WIDTH'($urandom);
            end
            rst = r; if_req = ip; if_addr = ia;
            dm_req = dp; dm_we = dw; dm_addr = da; dm_wdata = dd;
            #1;
            eg_dm = !r && dp && !(ip && starve >= int'(SMAX));
            eg_if = !r && ip && !eg_dm;
            check("rnd if_gnt", 32'(if_gnt), 32'(eg_if));
            check("rnd dm_gnt", 32'(dm_gnt), 32'(eg_dm));
            check("rnd if_rvalid", 32'(if_rvalid), 32'(!r && owner == 1));
            check("rnd dm_rvalid", 32'(dm_rvalid), 32'(!r && owner == 2));
            if (!r && owner == 1) check("rnd if_rdata", 32'(if_rdata), 32'(exp_data));
            if (!r && owner == 2) check("rnd dm_rdata", 32'(dm_rdata), 32'(exp_data));
            check("rnd bram_en", 32'(bram_en), 32'(eg_if || eg_dm));
            if (eg_if || eg_dm) begin
                check("rnd bram_addr", 32'(bram_addr), 32'(eg_dm ? da : ia));
                check("rnd bram_we", 32'(bram_we), 32'(eg_dm && dw));
            end
            if (eg_dm && dw) check("rnd bram_din", 32'(bram_din), 32'(dd));

            if (r) begin
                starve = 0; owner = 0;
            end else begin
                owner    = eg_if ? 1 : ((eg_dm && !dw) ? 2 : 0);
                exp_data = eg_if ? shadow[ia] : shadow[da];
                if (eg_dm && dw) shadow[da] = dd;
                starve = (ip && !eg_if) ? ((starve + 1 > int'(SMAX)) ? int'(SMAX) : starve + 1) : 0;
                if (eg_if) ip = 1'b0;
                if (eg_dm) dp = 1'b0;
            end
        end

        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0; rst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
